// File: rtl/sockit_fifo.sv
// Single-clock FIFO with req/grt handshake on both ports, fill level,
// almost-full/almost-empty flags, synchronous clear and optional bypass.
module sockit_fifo #(
  parameter int DW  = 8,
  parameter int FF  = 4,
  parameter int AF  = 2**FF-1,
  parameter int AE  = 1,
  parameter int BYP = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] ffi_bus,
  input  logic          ffi_req,
  output logic          ffi_grt,
  output logic [DW-1:0] ffo_bus,
  output logic          ffo_req,
  input  logic          ffo_grt,
  output logic [FF:0]   lvl,
  output logic          ffi_aff,
  output logic          ffo_aem
);

  localparam int D = 2**FF;
  localparam logic [FF:0]   D_L     = (FF+1)'(D);
  localparam logic [FF:0]   AF_L    = (FF+1)'(AF);
  localparam logic [FF:0]   AE_L    = (FF+1)'(AE);
  localparam logic [FF:0]   LVL_ONE = (FF+1)'(1);
  localparam logic [FF-1:0] PTR_ONE = FF'(1);

  logic [DW-1:0] mem [D];
  logic [FF-1:0] wr_ptr;
  logic [FF-1:0] rd_ptr;
  logic          req_q;
  logic          ffi_trn;
  logic          ffo_trn;
  logic          pass;
  logic          ffi_wr;
  logic          ffo_rd;
  logic [FF:0]   lvl_next;

  // req_q always mirrors (lvl != 0); in bypass mode an accepted input word
  // is offered to the sink in the same cycle while the queue is empty.
  always_comb begin
    ffi_trn  = ffi_req & ffi_grt;
    ffo_req  = req_q;
    ffo_bus  = mem[rd_ptr];
    if (BYP != 0) begin
      ffo_req = req_q | ffi_trn;
      if (lvl == '0) ffo_bus = ffi_bus;
    end
    ffo_trn  = ffo_req & ffo_grt;
    pass     = (BYP != 0) && (lvl == '0) && ffi_trn && ffo_grt;
    ffi_wr   = ffi_trn & ~pass;
    ffo_rd   = ffo_trn & ~pass;
    lvl_next = lvl;
    if (ffi_wr && !ffo_rd)
      lvl_next = lvl + LVL_ONE;
    else if (!ffi_wr && ffo_rd)
      lvl_next = lvl - LVL_ONE;
  end

  // Grant and flags are registered from lvl_next, so a read while full
  // only reopens the grant on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      lvl     <= '0;
      ffi_grt <= 1'b0;
      req_q   <= 1'b0;
      ffi_aff <= (AF_L == '0);
      ffo_aem <= 1'b1;
    end else if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      lvl     <= '0;
      ffi_grt <= 1'b1;
      req_q   <= 1'b0;
      ffi_aff <= (AF_L == '0);
      ffo_aem <= 1'b1;
    end else begin
      if (ffi_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (ffo_rd) rd_ptr <= rd_ptr + PTR_ONE;
      lvl     <= lvl_next;
      ffi_grt <= (lvl_next != D_L);
      req_q   <= (lvl_next != '0);
      ffi_aff <= (lvl_next >= AF_L);
      ffo_aem <= (lvl_next <= AE_L);
    end
  end

  // Words accepted during a clear cycle are dropped rather than stored.
  always_ff @(posedge clk) begin
    if (ffi_wr && !rst && !clr)
      mem[wr_ptr] <= ffi_bus;
  end

endmodule

// File: tb/tb_sockit_fifo.sv
// Bench for sockit_fifo: table-driven fill/drain, scoreboard stress,
// clear and reset corners on a registered instance, plus a bypass instance.
module tb_sockit_fifo;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic       a_rst, a_clr, a_ffi_req, a_ffi_grt, a_ffo_req, a_ffo_grt, a_aff, a_aem;
  logic [7:0] a_ffi_bus, a_ffo_bus;
  logic [2:0] a_lvl;
  logic       b_rst, b_clr, b_ffi_req, b_ffi_grt, b_ffo_req, b_ffo_grt, b_aff, b_aem;
  logic [7:0] b_ffi_bus, b_ffo_bus;
  logic [2:0] b_lvl;

  sockit_fifo #(.DW(8), .FF(2), .AF(3), .AE(1), .BYP(0)) u_dut (
    .clk(clk), .rst(a_rst), .clr(a_clr),
    .ffi_bus(a_ffi_bus), .ffi_req(a_ffi_req), .ffi_grt(a_ffi_grt),
    .ffo_bus(a_ffo_bus), .ffo_req(a_ffo_req), .ffo_grt(a_ffo_grt),
    .lvl(a_lvl), .ffi_aff(a_aff), .ffo_aem(a_aem)
  );

  sockit_fifo #(.DW(8), .FF(2), .AF(3), .AE(1), .BYP(1)) u_byp (
    .clk(clk), .rst(b_rst), .clr(b_clr),
    .ffi_bus(b_ffi_bus), .ffi_req(b_ffi_req), .ffi_grt(b_ffi_grt),
    .ffo_bus(b_ffo_bus), .ffo_req(b_ffo_req), .ffo_grt(b_ffo_grt),
    .lvl(b_lvl), .ffi_aff(b_aff), .ffo_aem(b_aem)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic       rst, clr, req;
    logic [7:0] bus;
    logic       grt;
    logic       e_grt, e_req;
    logic [2:0] e_lvl;
    logic       e_aff, e_aem;
    logic [7:0] e_head;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic req, input logic [7:0] bus,
                              input logic grt, input logic eg, input logic er,
                              input logic [2:0] el, input logic ea, input logic ee,
                              input logic [7:0] eh);
    vec_t v;
    v.rst = rst; v.clr = 1'b0; v.req = req; v.bus = bus; v.grt = grt;
    v.e_grt = eg; v.e_req = er; v.e_lvl = el; v.e_aff = ea; v.e_aem = ee; v.e_head = eh;
    return v;
  endfunction

  vec_t vecs[15];
  logic [7:0] q[$];
  logic [7:0] src_cnt;
  logic [7:0] exp_word;
  int         n_out;
  logic       in_trn, out_trn;

  initial begin
    a_rst = 1'b1; a_clr = 1'b0; a_ffi_req = 1'b0; a_ffi_bus = 8'h00; a_ffo_grt = 1'b0;
    b_rst = 1'b1; b_clr = 1'b0; b_ffi_req = 1'b0; b_ffi_bus = 8'h00; b_ffo_grt = 1'b0;

    //                rst   req   bus    grt  | e_grt e_req lvl   aff   aem   head
    vecs[0]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'h00);
    vecs[1]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'h00);
    vecs[2]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 8'h00);
    vecs[3]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 8'h00);
    vecs[4]  = mk(1'b0, 1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 8'h10);
    vecs[5]  = mk(1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 8'h10);
    vecs[6]  = mk(1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 8'h10);
    vecs[7]  = mk(1'b0, 1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 8'h10);
    vecs[8]  = mk(1'b0, 1'b1, 8'h14, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 8'h10);
    vecs[9]  = mk(1'b0, 1'b1, 8'h14, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 8'h10);
    vecs[10] = mk(1'b0, 1'b1, 8'h14, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 8'h11);
    vecs[11] = mk(1'b0, 1'b1, 8'h14, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 8'h12);
    vecs[12] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 8'h13);
    vecs[13] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 8'h14);
    vecs[14] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 15; i++) begin
      a_rst = vecs[i].rst; a_clr = vecs[i].clr; a_ffi_req = vecs[i].req;
      a_ffi_bus = vecs[i].bus; a_ffo_grt = vecs[i].grt;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d ffi_grt", i), 32'(a_ffi_grt), 32'(vecs[i].e_grt));
      check($sformatf("v%0d ffo_req", i), 32'(a_ffo_req), 32'(vecs[i].e_req));
      check($sformatf("v%0d lvl", i), 32'(a_lvl), 32'(vecs[i].e_lvl));
      check($sformatf("v%0d ffi_aff", i), 32'(a_aff), 32'(vecs[i].e_aff));
      check($sformatf("v%0d ffo_aem", i), 32'(a_aem), 32'(vecs[i].e_aem));
      if (vecs[i].e_req)
        check($sformatf("v%0d head", i), 32'(a_ffo_bus), 32'(vecs[i].e_head));
    end

    // Random stress with a scoreboard queue
    src_cnt = 8'h00;
    n_out = 0;
    for (int cyc = 0; cyc < 2000 && n_out < 64; cyc++) begin
      a_ffi_req = 1'($urandom_range(1));
      a_ffo_grt = 1'($urandom_range(1));
      a_ffi_bus = src_cnt;
      #1;
      check("stress ffi_grt", 32'(a_ffi_grt), 32'(q.size() != 4));
      check("stress ffo_req", 32'(a_ffo_req), 32'(q.size() != 0));
      in_trn  = a_ffi_req & a_ffi_grt;
      out_trn = a_ffo_req & a_ffo_grt;
      if (out_trn) begin
        exp_word = (q.size() != 0) ? q.pop_front() : 8'hxx;
        check("stress data", 32'(a_ffo_bus), 32'(exp_word));
        n_out++;
      end
      if (in_trn) begin
        q.push_back(src_cnt);
        src_cnt = src_cnt + 8'd1;
      end
      @(posedge clk);
      @(negedge clk);
      check("stress lvl", 32'(a_lvl), 32'(q.size()));
      check("stress aff", 32'(a_aff), 32'(q.size() >= 3));
      check("stress aem", 32'(a_aem), 32'(q.size() <= 1));
    end
    check("stress out count", 32'(n_out), 32'd64);

    // Clear: flush leftovers, refill three words, clear with both transfers
    a_ffi_req = 1'b0; a_ffo_grt = 1'b0; a_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    a_clr = 1'b0;
    check("flush lvl", 32'(a_lvl), 32'd0);
    for (int i = 0; i < 3; i++) begin
      a_ffi_req = 1'b1; a_ffi_bus = 8'h20 + 8'(i);
      @(posedge clk); @(negedge clk);
    end
    check("pre-clear lvl", 32'(a_lvl), 32'd3);
    a_clr = 1'b1; a_ffi_req = 1'b1; a_ffi_bus = 8'h77; a_ffo_grt = 1'b1;
    #1;
    check("clear ffo_req", 32'(a_ffo_req), 32'd1);
    check("clear sink word", 32'(a_ffo_bus), 32'h20);
    @(posedge clk); @(negedge clk);
    a_clr = 1'b0; a_ffi_req = 1'b0;
    check("post-clear lvl", 32'(a_lvl), 32'd0);
    check("post-clear ffo_req", 32'(a_ffo_req), 32'd0);
    check("post-clear ffi_grt", 32'(a_ffi_grt), 32'd1);
    check("post-clear aem", 32'(a_aem), 32'd1);
    check("post-clear aff", 32'(a_aff), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("cleared stays empty", 32'(a_ffo_req), 32'd0);
    end
    a_ffo_grt = 1'b0; a_ffi_req = 1'b1; a_ffi_bus = 8'h30;
    @(posedge clk); @(negedge clk);
    a_ffi_req = 1'b0;
    check("after clear head", 32'(a_ffo_bus), 32'h30);
    check("after clear lvl", 32'(a_lvl), 32'd1);

    // Reset mid-operation discards contents, grant low for one cycle
    a_rst = 1'b1; a_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    a_rst = 1'b0; a_clr = 1'b0;
    check("midrst lvl", 32'(a_lvl), 32'd0);
    check("midrst ffi_grt", 32'(a_ffi_grt), 32'd0);
    check("midrst ffo_req", 32'(a_ffo_req), 32'd0);
    @(posedge clk); @(negedge clk);
    check("midrst grt rises", 32'(a_ffi_grt), 32'd1);

    // Bypass instance
    b_rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("byp ffi_grt", 32'(b_ffi_grt), 32'd1);
    check("byp idle req", 32'(b_ffo_req), 32'd0);
    b_ffi_req = 1'b1; b_ffi_bus = 8'hA5; b_ffo_grt = 1'b1;
    #1;
    check("byp pass req", 32'(b_ffo_req), 32'd1);
    check("byp pass bus", 32'(b_ffo_bus), 32'hA5);
    @(posedge clk); @(negedge clk);
    check("byp pass lvl", 32'(b_lvl), 32'd0);
    b_ffo_grt = 1'b0;
    #1;
    check("byp store req", 32'(b_ffo_req), 32'd1);
    @(posedge clk); @(negedge clk);
    check("byp store lvl", 32'(b_lvl), 32'd1);
    b_ffi_req = 1'b0; b_ffi_bus = 8'h00; b_ffo_grt = 1'b1;
    #1;
    check("byp stored req", 32'(b_ffo_req), 32'd1);
    check("byp stored bus", 32'(b_ffo_bus), 32'hA5);
    @(posedge clk); @(negedge clk);
    check("byp drained lvl", 32'(b_lvl), 32'd0);
    check("byp drained req", 32'(b_ffo_req), 32'd0);
    b_ffi_req = 1'b1; b_ffi_bus = 8'h11; b_ffo_grt = 1'b0;
    @(posedge clk); @(negedge clk);
    b_ffi_bus = 8'h22; b_ffo_grt = 1'b1;
    #1;
    check("byp order bus", 32'(b_ffo_bus), 32'h11);
    @(posedge clk); @(negedge clk);
    check("byp order lvl", 32'(b_lvl), 32'd1);
    b_ffi_req = 1'b0;
    #1;
    check("byp order next", 32'(b_ffo_bus), 32'h22);
    @(posedge clk); @(negedge clk);
    check("byp order empty", 32'(b_lvl), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
